// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared op encodings, FSM states and XLEN for the sequential mul/div unit.
package muldiv_seq_pkg;
    localparam int XLEN = 32;
    typedef enum logic [2:0] {
        MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU,
        MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU
    } md_op_e;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/muldiv_seq_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or (with MULDIV_DIV_EN) restoring divide.
module muldiv_step
    import muldiv_seq_pkg::*;
(
`ifdef MULDIV_DIV_EN
    input  logic            div,
`endif
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] hi_n,
    output logic [XLEN-1:0] lo_n
);
    logic [XLEN:0] sum;
    assign sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
`ifdef MULDIV_DIV_EN
    logic [XLEN:0] sh, diff;
    assign sh   = {hi, lo[XLEN-1]};
    assign diff = sh - {1'b0, a};
    // Borrow out of the trial subtraction means the divisor did not fit.
    assign {hi_n, lo_n} = div ? {diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0], lo[XLEN-2:0], ~diff[XLEN]}
                              : {sum, lo[XLEN-1:1]};
`else
    assign {hi_n, lo_n} = {sum, lo[XLEN-1:1]};
`endif
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-step sequential RV32M multiply/divide; divide support only with MULDIV_DIV_EN.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            ready_o,
    output logic            valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o,
    input  logic            flush_i
);
    state_t state, state_n;
    logic [4:0] cnt;
    logic [2:0] op;
    logic neg, neg_i, s1, s2, accept, bypass;
    logic [XLEN-1:0] a, hi, lo, hi_n, lo_n, m1, m2, bres, fin;
    logic [2*XLEN-1:0] pn;

    assign ready_o = state == IDLE;
    assign valid_o = state == DONE;
    assign busy_o  = state != IDLE;
    assign accept  = valid_i && ready_o && !flush_i;

    assign s1 = (op_i == MD_OP_MULH || op_i == MD_OP_MULHSU || op_i == MD_OP_DIV || op_i == MD_OP_REM) && rs1_i[XLEN-1];
    assign s2 = (op_i == MD_OP_MULH || op_i == MD_OP_DIV || op_i == MD_OP_REM) && rs2_i[XLEN-1];
    assign m1 = s1 ? -rs1_i : rs1_i;
    assign m2 = s2 ? -rs2_i : rs2_i;
    // Remainder takes the dividend's sign; products and quotients take the XOR.
    assign neg_i = op_i == MD_OP_REM ? s1 : s1 ^ s2;
    assign pn = neg ? -{hi_n, lo_n} : {hi_n, lo_n};

`ifdef MULDIV_DIV_EN
    logic dz, ovf;
    assign dz     = op_i[2] && rs2_i == '0;
    assign ovf    = (op_i == MD_OP_DIV || op_i == MD_OP_REM) && rs1_i == 32'h8000_0000 && rs2_i == 32'hFFFF_FFFF;
    assign bypass = dz || ovf;
    assign bres   = dz ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : 32'h8000_0000);
    assign fin    = op[2] ? (op[1] ? (neg ? -hi_n : hi_n) : (neg ? -lo_n : lo_n))
                          : (op == MD_OP_MUL ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN]);
    muldiv_step u_step (.div(op[2]), .a(a), .hi(hi), .lo(lo), .hi_n(hi_n), .lo_n(lo_n));
`else
    assign bypass = op_i[2];
    assign bres   = '0;
    assign fin    = op == MD_OP_MUL ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN];
    muldiv_step u_step (.a(a), .hi(hi), .lo(lo), .hi_n(hi_n), .lo_n(lo_n));
`endif

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = accept ? (bypass ? DONE : BUSY) : IDLE;
            BUSY: state_n = cnt == 5'd31 ? DONE : BUSY;
            DONE: state_n = result_ready_i ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
        if (flush_i) state_n = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            cnt      <= '0;
            op       <= '0;
            neg      <= 1'b0;
            a        <= '0;
            hi       <= '0;
            lo       <= '0;
            result_o <= '0;
        end else if (flush_i) begin
            cnt      <= '0;
            result_o <= '0;
        end else if (accept) begin
            cnt <= '0;
            op  <= op_i;
            neg <= neg_i;
            a   <= m2;
            hi  <= '0;
            lo  <= m1;
            if (bypass) result_o <= bres;
        end else if (state == BUSY) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) result_o <= fin;
        end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed-vector bench for muldiv_seq; expectations follow MULDIV_DIV_EN.
module tb_muldiv_seq;
`ifdef MULDIV_DIV_EN
    localparam bit DE = 1'b1;
`else
    localparam bit DE = 1'b0;
`endif
    logic clk_i, rst_n_i, valid_i, ready_o, valid_o, result_ready_i, busy_o, flush_i;
    logic [2:0] op_i;
    logic [31:0] rs1_i, rs2_i, result_o;
    int vec = 0, err = 0;
    logic seen;
    logic [31:0] hold_r;

    muldiv_seq dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .op_i(op_i), .rs1_i(rs1_i),
                    .rs2_i(rs2_i), .ready_o(ready_o), .valid_o(valid_o), .result_ready_i(result_ready_i),
                    .result_o(result_o), .busy_o(busy_o), .flush_i(flush_i));

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk_i);
        op_i = op; rs1_i = x; rs2_i = y; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; op_i = 3'($urandom);
    endtask

    task automatic await(input string tag, input int lat, input logic [31:0] exp);
        int n = 0;
        while (!valid_o && n < 64) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk({tag, ".lat"}, 32'(n), 32'(lat));
        chk(tag, result_o, exp);
    endtask

    task automatic take(input string tag);
        @(negedge clk_i);
        chk({tag, ".rdy_in_done"}, {31'b0, ready_o}, 32'd0);
        result_ready_i = 1'b1;
        @(posedge clk_i); #1;
        result_ready_i = 1'b0;
        chk({tag, ".valid_after"}, {31'b0, valid_o}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input int lat, input logic [31:0] exp);
        issue(op, x, y);
        await(tag, lat, exp);
        take(tag);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".ready"}, {31'b0, ready_o}, 32'd1);
        chk({tag, ".valid"}, {31'b0, valid_o}, 32'd0);
        chk({tag, ".busy"}, {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        rst_n_i = 1'b0; valid_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
        result_ready_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        idle_chk("reset");
        chk("reset.result", result_o, 32'd0);
        @(negedge clk_i) rst_n_i = 1'b1;

        run("mul_7x6",      3'b000, 32'd7,          32'd6,          32, 32'd42);
        run("mulh_m1xm1",   3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF,   32, 32'd0);
        run("mulhu_m1xm1",  3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF,   32, 32'hFFFFFFFE);
        run("mulhsu_m1x2",  3'b010, 32'hFFFFFFFF,   32'd2,          32, 32'hFFFFFFFF);
        run("mul_2p32",     3'b000, 32'h00010000,   32'h00010000,   32, 32'd0);
        run("mulhu_2p32",   3'b011, 32'h00010000,   32'h00010000,   32, 32'd1);
        run("mulh_m3x5",    3'b001, 32'hFFFFFFFD,   32'd5,          32, 32'hFFFFFFFF);
        run("mul_m3x5",     3'b000, 32'hFFFFFFFD,   32'd5,          32, 32'hFFFFFFF1);

        run("div_m7_2",     3'b100, 32'hFFFFFFF9,   32'd2,          DE ? 32 : 0, DE ? 32'hFFFFFFFD : 32'd0);
        run("rem_m7_2",     3'b110, 32'hFFFFFFF9,   32'd2,          DE ? 32 : 0, DE ? 32'hFFFFFFFF : 32'd0);
        run("div_7_m2",     3'b100, 32'd7,          32'hFFFFFFFE,   DE ? 32 : 0, DE ? 32'hFFFFFFFD : 32'd0);
        run("rem_7_m2",     3'b110, 32'd7,          32'hFFFFFFFE,   DE ? 32 : 0, DE ? 32'd1 : 32'd0);
        run("divu_100_7",   3'b101, 32'd100,        32'd7,          DE ? 32 : 0, DE ? 32'd14 : 32'd0);
        run("remu_100_7",   3'b111, 32'd100,        32'd7,          DE ? 32 : 0, DE ? 32'd2 : 32'd0);
        run("divu_big",     3'b101, 32'hFFFFFFFF,   32'd1,          DE ? 32 : 0, DE ? 32'hFFFFFFFF : 32'd0);
        run("divu_5_0",     3'b101, 32'd5,          32'd0,          0, DE ? 32'hFFFFFFFF : 32'd0);
        run("rem_5_0",      3'b110, 32'd5,          32'd0,          0, DE ? 32'd5 : 32'd0);
        run("rem_ovf",      3'b110, 32'h80000000,   32'hFFFFFFFF,   0, 32'd0);
        run("div_ovf",      3'b100, 32'h80000000,   32'hFFFFFFFF,   0, DE ? 32'h80000000 : 32'd0);

        issue(3'b000, 32'd3, 32'd5);
        await("hold", 32, 32'd15);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            chk("hold.valid", {31'b0, valid_o}, 32'd1);
            chk("hold.result", result_o, 32'd15);
        end
        take("hold");

        issue(3'b000, 32'd7, 32'd6);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i) flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        idle_chk("flush");
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (valid_o) seen = 1'b1;
        end
        chk("flush.no_result", {31'b0, seen}, 32'd0);
        run("mul_3x3", 3'b000, 32'd3, 32'd3, 32, 32'd9);

        @(negedge clk_i);
        op_i = 3'b000; rs1_i = 32'd2; rs2_i = 32'd2; valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        idle_chk("flush_wins");

        issue(3'b000, 32'd7, 32'd6);
        await("prev", 32, 32'd42);
        hold_r = result_o;
        take("prev");
        issue(3'b000, 32'd9, 32'd9);
        repeat (5) @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        idle_chk("rst_busy");
        chk("rst_busy.result", result_o, 32'd0);
        chk("rst_busy.prev_cleared", result_o ^ hold_r, 32'd42);
        @(negedge clk_i) rst_n_i = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (valid_o) seen = 1'b1;
        end
        chk("rst_busy.no_result", {31'b0, seen}, 32'd0);
        run("mul_after_rst", 3'b000, 32'd12, 32'd11, 32, 32'd132);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
